mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_if.sv | 23 ++
 rtl/mux4_rr_arbiter.sv | 101 ++++++++++
 tb/tb_mux4_rr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Requester/consumer bundle for mux4_rr_arbiter: four req/data lanes in, one valid/ready beat out.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] in_data;
    logic [3:0]         lock;
    logic [3:0]         ack;
    logic [1:0]         sel;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;

    modport master (
        output req, in_data, lock, out_ready,
        input  ack, sel, out_valid, out_data
    );

    modport slave (
        input  req, in_data, lock, out_ready,
        output ack, sel, out_valid, out_data
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter feeding one registered valid/ready output beat.
// Optional grant locking is enabled by defining ARB_LOCK_EN.
module mux4_rr_arbiter #(
    parameter int WIDTH = 8
) (
    input logic              clk,
    input logic              rst_n,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;
    logic             can_load;
    logic             load;
    logic [WIDTH-1:0] data_q;
    logic [1:0]       sel_q;

`ifdef ARB_LOCK_EN
    logic lock_flag;
`else
    logic unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Rotating priority starting just after the last granted index.
    always_comb begin
        winner = ptr;
        cand   = ptr;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && bus.req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
`ifdef ARB_LOCK_EN
        if (lock_flag && bus.req[ptr]) begin
            winner = ptr;
        end
`endif
    end

    assign can_load = (state == IDLE) || bus.out_ready;
    assign load     = rst_n && (|bus.req) && can_load;

    always_comb begin
        state_next = state;
        bus.ack    = 4'b0000;
        if (load) begin
            state_next = HOLD;
            bus.ack    = 4'(1) << winner;
        end else if (state == HOLD && bus.out_ready) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr    <= 2'd3;
            data_q <= '0;
            sel_q  <= 2'd0;
        end else if (load) begin
            ptr    <= winner;
            data_q <= bus.in_data[winner*WIDTH +: WIDTH];
            sel_q  <= winner;
        end
    end

`ifdef ARB_LOCK_EN
    // A load opportunity that does not re-grant the locked owner ends the lock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_flag <= 1'b0;
        end else if (can_load) begin
            if (load) begin
                lock_flag <= bus.lock[winner];
            end else begin
                lock_flag <= 1'b0;
            end
        end
    end
`endif

    assign bus.out_valid = (state == HOLD);
    assign bus.out_data  = data_q;
    assign bus.sel       = sel_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed vector bench for mux4_rr_arbiter: table of per-cycle stimulus/expectations plus a lock sequence.
module tb_mux4_rr_arbiter;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic        rdy;
        logic [3:0]  exp_ack;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [1:0]  exp_sel;
    } vec_t;

    vec_t vecs[64];
    int   nv;

    localparam logic [31:0] DA = 32'hA3A2A1A0;

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic rd,
                       input logic [3:0] ea, input logic ev, input logic [7:0] ed, input logic [1:0] es);
        vecs[nv] = '{r, rq, d, rd, ea, ev, ed, es};
        nv++;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog step=0 actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [1:0] lock_sel[6];
    logic [3:0] lock_pat[6];

    initial begin
        checks   = 0;
        failures = 0;
        nv       = 0;
        rst_n    = 1'b0;
        bus.req       = 4'h0;
        bus.in_data   = '0;
        bus.lock      = 4'h0;
        bus.out_ready = 1'b0;

        // Reset with everything requesting.
        add(0, 4'hF, DA, 1, 4'h0, 0, 8'h00, 2'd0);
        add(0, 4'hF, DA, 1, 4'h0, 0, 8'h00, 2'd0);
        // Fair rotation.
        add(1, 4'hF, DA, 1, 4'h1, 1, 8'hA0, 2'd0);
        add(1, 4'hF, DA, 1, 4'h2, 1, 8'hA1, 2'd1);
        add(1, 4'hF, DA, 1, 4'h4, 1, 8'hA2, 2'd2);
        add(1, 4'hF, DA, 1, 4'h8, 1, 8'hA3, 2'd3);
        add(1, 4'hF, DA, 1, 4'h1, 1, 8'hA0, 2'd0);
        add(1, 4'hF, DA, 1, 4'h2, 1, 8'hA1, 2'd1);
        add(1, 4'hF, DA, 1, 4'h4, 1, 8'hA2, 2'd2);
        add(1, 4'hF, DA, 1, 4'h8, 1, 8'hA3, 2'd3);
        // Skip idle requesters.
        add(1, 4'h9, DA, 1, 4'h1, 1, 8'hA0, 2'd0);
        add(1, 4'h9, DA, 1, 4'h8, 1, 8'hA3, 2'd3);
        add(1, 4'h9, DA, 1, 4'h1, 1, 8'hA0, 2'd0);
        add(1, 4'h9, DA, 1, 4'h8, 1, 8'hA3, 2'd3);
        // Drain to IDLE, data and sel retained.
        add(1, 4'h0, DA, 1, 4'h0, 0, 8'hA3, 2'd3);
        // Backpressure on a single beat from requester 2.
        add(1, 4'h4, 32'h005C0000, 0, 4'h4, 1, 8'h5C, 2'd2);
        for (int i = 0; i < 5; i++) add(1, 4'h0, 32'h005C0000, 0, 4'h0, 1, 8'h5C, 2'd2);
        add(1, 4'h0, 32'h005C0000, 1, 4'h0, 0, 8'h5C, 2'd2);
        add(1, 4'h0, 32'h005C0000, 0, 4'h0, 0, 8'h5C, 2'd2);
        // IDLE loads regardless of out_ready; waiting request; same-edge handshake and reload.
        add(1, 4'h1, 32'h00000011, 0, 4'h1, 1, 8'h11, 2'd0);
        add(1, 4'h2, 32'h00002200, 0, 4'h0, 1, 8'h11, 2'd0);
        add(1, 4'h2, 32'h00002200, 1, 4'h2, 1, 8'h22, 2'd1);
        add(1, 4'h0, 32'h00002200, 1, 4'h0, 0, 8'h22, 2'd1);
        // Reset while holding a beat, then reset priority applies.
        add(1, 4'h4, 32'h00660000, 0, 4'h4, 1, 8'h66, 2'd2);
        add(0, 4'hF, DA, 0, 4'h0, 0, 8'h00, 2'd0);
        add(1, 4'hF, DA, 1, 4'h1, 1, 8'hA0, 2'd0);
        add(1, 4'hF, DA, 1, 4'h2, 1, 8'hA1, 2'd1);
        add(1, 4'h0, DA, 1, 4'h0, 0, 8'hA1, 2'd1);

        @(posedge clk);
        #1;
        for (int i = 0; i < nv; i++) begin
            rst_n         = vecs[i].rst_n;
            bus.req       = vecs[i].req;
            bus.in_data   = vecs[i].data;
            bus.out_ready = vecs[i].rdy;
            bus.lock      = 4'h0;
            @(negedge clk);
            chk("ack", i, 32'(bus.ack), 32'(vecs[i].exp_ack));
            @(posedge clk);
            #1;
            chk("out_valid", i, 32'(bus.out_valid), 32'(vecs[i].exp_valid));
            chk("out_data", i, 32'(bus.out_data), 32'(vecs[i].exp_data));
            chk("sel", i, 32'(bus.sel), 32'(vecs[i].exp_sel));
        end

        // Lock sequence: lock[1] high on the first two captures of requester 1.
        lock_pat = '{4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 4'h0};
`ifdef ARB_LOCK_EN
        lock_sel = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
`else
        lock_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
        rst_n   = 1'b0;
        bus.req = 4'h0;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        bus.req       = 4'hF;
        bus.in_data   = DA;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.lock = lock_pat[i];
            @(negedge clk);
            chk("lock_ack", i, 32'(bus.ack), 32'(4'(1) << lock_sel[i]));
            @(posedge clk);
            #1;
            chk("lock_sel", i, 32'(bus.sel), 32'(lock_sel[i]));
        end
        bus.req  = 4'h0;
        bus.lock = 4'h0;
        @(posedge clk);
        #1;
        chk("lock_drain", 0, 32'(bus.out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
